// File: rtl/piece_drop.sv
// Active-piece controller: accepts a spawned board, moves the piece under lateral/gravity
// requests, locks it and hands the settled board back. Optional macro: HARD_DROP_EN.
module piece_drop (
    input  logic        clka,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] board_in,
    input  logic [1:0]  piece_in,
    input  logic        spawn_error,
    input  logic        move_left,
    input  logic        move_right,
    input  logic        drop_tick,
`ifdef HARD_DROP_EN
    input  logic        hard_drop,
`endif
    output logic [31:0] board_out,
    output logic        board_valid,
    output logic [31:0] display,
    output logic        busy,
    output logic        game_over
);

`ifdef HARD_DROP_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_FALL, ST_LOCK, ST_GAME_OVER, ST_DROP
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_FALL, ST_LOCK, ST_GAME_OVER
    } state_t;
`endif

    state_t      state_reg, state_next;
    logic [31:0] mask_reg, mask_next;
    logic [31:0] settled_reg, settled_next;
    logic [31:0] board_out_reg, board_out_next;
    logic [31:0] display_reg, display_next;
    logic [31:0] spawn_mask;
    logic [31:0] lat_mask;

    function automatic logic left_ok(input logic [31:0] m, input logic [31:0] s);
        return ((m & 32'h1111_1111) == 32'h0) && (((m >> 1) & s) == 32'h0);
    endfunction

    function automatic logic right_ok(input logic [31:0] m, input logic [31:0] s);
        return ((m & 32'h8888_8888) == 32'h0) && (((m << 1) & s) == 32'h0);
    endfunction

    function automatic logic down_ok(input logic [31:0] m, input logic [31:0] s);
        return (m[31:28] == 4'h0) && (((m << 4) & s) == 32'h0);
    endfunction

    always_comb begin
        case (piece_in)
            2'b00:   spawn_mask = 32'h0000_0002;
            2'b01:   spawn_mask = 32'h0000_0006;
            2'b10:   spawn_mask = 32'h0000_0066;
            default: spawn_mask = 32'h0000_0062;
        endcase
    end

    // Conflicting left+right requests cancel; illegal moves are dropped silently.
    always_comb begin
        lat_mask = mask_reg;
        if (move_left && !move_right && left_ok(mask_reg, settled_reg))
            lat_mask = mask_reg >> 1;
        else if (move_right && !move_left && right_ok(mask_reg, settled_reg))
            lat_mask = mask_reg << 1;
    end

    always_comb begin
        state_next     = state_reg;
        mask_next      = mask_reg;
        settled_next   = settled_reg;
        board_out_next = board_out_reg;
        display_next   = display_reg;
        case (state_reg)
            ST_IDLE: begin
                if (load) begin
                    mask_next    = spawn_mask;
                    settled_next = board_in & ~spawn_mask;
                    display_next = board_in | spawn_mask;
                    state_next   = spawn_error ? ST_GAME_OVER : ST_FALL;
                end
            end
            ST_FALL: begin
`ifdef HARD_DROP_EN
                if (hard_drop) begin
                    state_next = ST_DROP;
                end else
`endif
                begin
                    mask_next = lat_mask;
                    if (drop_tick) begin
                        if (down_ok(lat_mask, settled_reg)) begin
                            mask_next = lat_mask << 4;
                        end else begin
                            state_next     = ST_LOCK;
                            board_out_next = settled_reg | lat_mask;
                        end
                    end
                    display_next = settled_reg | mask_next;
                end
            end
`ifdef HARD_DROP_EN
            ST_DROP: begin
                if (down_ok(mask_reg, settled_reg)) begin
                    mask_next = mask_reg << 4;
                end else begin
                    state_next     = ST_LOCK;
                    board_out_next = settled_reg | mask_reg;
                end
                display_next = settled_reg | mask_next;
            end
`endif
            ST_LOCK: begin
                // board_out was captured on the way in; the piece leaves the display now.
                state_next   = ST_IDLE;
                display_next = settled_reg;
            end
            ST_GAME_OVER: begin
                state_next = ST_GAME_OVER;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clka) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            mask_reg      <= 32'h0;
            settled_reg   <= 32'h0;
            board_out_reg <= 32'h0;
            display_reg   <= 32'h0;
        end else begin
            state_reg     <= state_next;
            mask_reg      <= mask_next;
            settled_reg   <= settled_next;
            board_out_reg <= board_out_next;
            display_reg   <= display_next;
        end
    end

    assign board_out   = board_out_reg;
    assign display     = display_reg;
    assign board_valid = (state_reg == ST_LOCK);
    assign game_over   = (state_reg == ST_GAME_OVER);
`ifdef HARD_DROP_EN
    assign busy = (state_reg == ST_FALL) || (state_reg == ST_LOCK) || (state_reg == ST_DROP);
`else
    assign busy = (state_reg == ST_FALL) || (state_reg == ST_LOCK);
`endif

endmodule

// File: tb/tb_piece_drop.sv
// Directed self-checking bench for piece_drop.
module tb_piece_drop;
    logic        clka = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [31:0] board_in = 32'h0;
    logic [1:0]  piece_in = 2'b00;
    logic        spawn_error = 1'b0;
    logic        move_left = 1'b0;
    logic        move_right = 1'b0;
    logic        drop_tick = 1'b0;
`ifdef HARD_DROP_EN
    logic        hard_drop = 1'b0;
`endif
    logic [31:0] board_out;
    logic        board_valid;
    logic [31:0] display;
    logic        busy;
    logic        game_over;

    int checks = 0;
    int errors = 0;

    piece_drop dut (
        .clka(clka), .reset(reset), .load(load), .board_in(board_in),
        .piece_in(piece_in), .spawn_error(spawn_error),
        .move_left(move_left), .move_right(move_right), .drop_tick(drop_tick),
`ifdef HARD_DROP_EN
        .hard_drop(hard_drop),
`endif
        .board_out(board_out), .board_valid(board_valid), .display(display),
        .busy(busy), .game_over(game_over)
    );

    always #5 clka = ~clka;

    // Stimulus helpers: called at a negedge, return at the following negedge.
    task automatic ld(input logic [31:0] b, input logic [1:0] p, input logic e);
        load = 1'b1; board_in = b; piece_in = p; spawn_error = e;
        @(negedge clka);
        load = 1'b0; spawn_error = 1'b0;
        $display("load board=%h piece=%0d err=%0b -> display=%h busy=%0b go=%0b",
                 b, p, e, display, busy, game_over);
    endtask

    task automatic drive(input logic l, input logic r, input logic t);
        move_left = l; move_right = r; drop_tick = t;
        @(negedge clka);
        move_left = 1'b0; move_right = 1'b0; drop_tick = 1'b0;
        $display("move L=%0b R=%0b T=%0b -> display=%h bv=%0b board_out=%h",
                 l, r, t, display, board_valid, board_out);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        @(negedge clka);
        @(negedge clka);
        checks++;
        if (display !== 32'h0) begin errors++; $display("FAIL reset_display: got %h expected %h", display, 32'h0); end
        checks++;
        if (board_out !== 32'h0) begin errors++; $display("FAIL reset_board_out: got %h expected %h", board_out, 32'h0); end
        checks++;
        if ({board_valid, busy, game_over} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b expected %b", {board_valid, busy, game_over}, 3'b000);
        end
        reset = 1'b0;
    endtask

    task automatic test_square_fall;
        logic [31:0] exp;
        ld(32'h0000_0066, 2'b10, 1'b0);
        checks++;
        if (display !== 32'h0000_0066) begin errors++; $display("FAIL sq_spawn: got %h expected %h", display, 32'h66); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL sq_busy: got %b expected 1", busy); end
        exp = 32'h0000_0066;
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 1'b1);
            exp = exp << 4;
            checks++;
            if (display !== exp) begin errors++; $display("FAIL sq_tick%0d: got %h expected %h", i, display, exp); end
        end
        drive(1'b0, 1'b0, 1'b1);
        checks++;
        if (board_valid !== 1'b1) begin errors++; $display("FAIL sq_valid: got %b expected 1", board_valid); end
        checks++;
        if (board_out !== 32'h6600_0000) begin errors++; $display("FAIL sq_board_out: got %h expected %h", board_out, 32'h66000000); end
        @(negedge clka);
        checks++;
        if ({board_valid, busy} !== 2'b00) begin errors++; $display("FAIL sq_idle: got %b expected 00", {board_valid, busy}); end
        checks++;
        if (board_out !== 32'h6600_0000) begin errors++; $display("FAIL sq_hold: got %h expected %h", board_out, 32'h66000000); end
    endtask

    task automatic test_walls;
        logic [31:0] exp_l [2];
        logic [31:0] exp_r [4];
        exp_l = '{32'h1, 32'h1};
        exp_r = '{32'h2, 32'h4, 32'h8, 32'h8};
        ld(32'h0000_0002, 2'b00, 1'b0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            checks++;
            if (display !== exp_l[i]) begin errors++; $display("FAIL wall_left%0d: got %h expected %h", i, display, exp_l[i]); end
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            checks++;
            if (display !== exp_r[i]) begin errors++; $display("FAIL wall_right%0d: got %h expected %h", i, display, exp_r[i]); end
        end
        drive(1'b1, 1'b1, 1'b0);
        checks++;
        if (display !== 32'h8) begin errors++; $display("FAIL wall_both: got %h expected %h", display, 32'h8); end
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 1'b1);
        checks++;
        if (board_valid !== 1'b1 || board_out !== 32'h8000_0000) begin
            errors++; $display("FAIL wall_lock: got bv=%b out=%h expected bv=1 out=%h", board_valid, board_out, 32'h80000000);
        end
        @(negedge clka);
    endtask

    task automatic test_back_to_back;
        ld(32'h8000_0002, 2'b00, 1'b0);
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 1'b1);
        checks++;
        if (board_valid !== 1'b1 || board_out !== 32'hA000_0000) begin
            errors++; $display("FAIL b2b_lock: got bv=%b out=%h expected bv=1 out=%h", board_valid, board_out, 32'hA0000000);
        end
        // Load during LOCK must be ignored.
        ld(32'h0000_0066, 2'b10, 1'b0);
        checks++;
        if (busy !== 1'b0 || display !== 32'h8000_0000) begin
            errors++; $display("FAIL b2b_ignored: got busy=%b display=%h expected busy=0 display=%h", busy, display, 32'h80000000);
        end
    endtask

    task automatic test_stack;
        ld(32'h0000_2002, 2'b00, 1'b0);
        checks++;
        if (busy !== 1'b1 || display !== 32'h2002) begin
            errors++; $display("FAIL stack_load: got busy=%b display=%h expected busy=1 display=%h", busy, display, 32'h2002);
        end
        drive(1'b0, 1'b0, 1'b1);
        checks++;
        if (display !== 32'h2020) begin errors++; $display("FAIL stack_tick1: got %h expected %h", display, 32'h2020); end
        drive(1'b0, 1'b0, 1'b1);
        checks++;
        if (display !== 32'h2200) begin errors++; $display("FAIL stack_tick2: got %h expected %h", display, 32'h2200); end
        drive(1'b0, 1'b0, 1'b1);
        checks++;
        if (board_valid !== 1'b1 || board_out !== 32'h2200) begin
            errors++; $display("FAIL stack_lock: got bv=%b out=%h expected bv=1 out=%h", board_valid, board_out, 32'h2200);
        end
        @(negedge clka);
        checks++;
        if (display !== 32'h2000) begin errors++; $display("FAIL stack_idle_display: got %h expected %h", display, 32'h2000); end
    endtask

    task automatic test_simultaneous;
        ld(32'h0000_0002, 2'b00, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        checks++;
        if (display !== 32'h40) begin errors++; $display("FAIL simul: got %h expected %h", display, 32'h40); end
    endtask

    task automatic test_reset_mid_fall;
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1);
        checks++;
        if (display !== 32'h0004_0000) begin errors++; $display("FAIL mid_pre: got %h expected %h", display, 32'h40000); end
        reset = 1'b1;
        @(negedge clka);
        reset = 1'b0;
        checks++;
        if (display !== 32'h0 || board_out !== 32'h0) begin
            errors++; $display("FAIL mid_reset: got display=%h out=%h expected 0", display, board_out);
        end
        checks++;
        if ({board_valid, busy, game_over} !== 3'b000) begin
            errors++; $display("FAIL mid_flags: got %b expected 000", {board_valid, busy, game_over});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clka);
            checks++;
            if (board_valid !== 1'b0) begin errors++; $display("FAIL mid_no_valid%0d: got %b expected 0", i, board_valid); end
        end
        ld(32'h0000_0066, 2'b10, 1'b0);
        checks++;
        if (busy !== 1'b1 || display !== 32'h66) begin
            errors++; $display("FAIL mid_reload: got busy=%b display=%h expected busy=1 display=%h", busy, display, 32'h66);
        end
    endtask

    task automatic test_spawn_error;
        reset = 1'b1;
        @(negedge clka);
        reset = 1'b0;
        ld(32'h0000_0066, 2'b10, 1'b1);
        checks++;
        if (game_over !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL spawn_err: got go=%b busy=%b expected go=1 busy=0", game_over, busy);
        end
        ld(32'h0000_0002, 2'b00, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        checks++;
        if (game_over !== 1'b1 || busy !== 1'b0 || board_valid !== 1'b0) begin
            errors++; $display("FAIL spawn_sticky: got go=%b busy=%b bv=%b expected 1 0 0", game_over, busy, board_valid);
        end
        reset = 1'b1;
        @(negedge clka);
        reset = 1'b0;
        checks++;
        if (game_over !== 1'b0) begin errors++; $display("FAIL spawn_clear: got %b expected 0", game_over); end
    endtask

    initial begin
        test_reset();
        test_square_fall();
        test_walls();
        test_back_to_back();
        test_stack();
        test_simultaneous();
        test_reset_mid_fall();
        test_spawn_error();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/piece_drop.md
# piece_drop

Active-piece controller that feeds the line-clear/respawn stage. It accepts the board handed back by the clear/respawn stage, including the freshly spawned piece and its spawn-collision flag. It then moves the piece under gravity ticks and left/right requests, and locks it when it can no longer fall. The settled board goes back out for the next clear/respawn pass, so this block closes the game loop from the opposite end of the 32-bit board interface.

## Interface
- Parameters: none (board geometry fixed at 8 rows x 4 columns).
- clka  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- load  in  1  board_in/piece_in/spawn_error valid (1-cycle pulse)
- board_in  in  32  board from clear/respawn stage, spawned piece already set
- piece_in  in  2  type of spawned piece (00 single, 01 pair, 10 square, 11 L)
- spawn_error  in  1  spawn overlapped existing cells
- move_left  in  1  request shift one column left
- move_right  in  1  request shift one column right
- drop_tick  in  1  gravity strobe (1-cycle pulse)
- hard_drop  in  1  only when HARD_DROP_EN defined
- board_out  out  32  locked board (settled | piece)
- board_valid  out  1  1-cycle pulse, board_out valid
- display  out  32  settled | active piece, registered
- busy  out  1  high in FALL and LOCK
- game_over  out  1  sticky until reset

## Operation
- Board encoding: cell (row r, col c) = bit 4r+c. Row 0 = bits[3:0] = top; row 7 = bits[31:28] = bottom. Falling = increasing row.
- Spawn masks (piece_in): 00 -> 0x00000002, 01 -> 0x00000006, 10 -> 0x00000066, 11 -> 0x00000062.
- On load in IDLE:
  - mask = spawn mask; settled = board_in & ~mask.
  - If spawn_error = 1, go to GAME_OVER; otherwise go to FALL.
- load outside IDLE is ignored.
- States:
  - IDLE: wait for load.
  - FALL: active piece moves.
  - LOCK: one cycle; board_out <= settled | mask and board_valid = 1, then IDLE.
  - GAME_OVER: absorbing; only reset exits.
- FALL, each cycle:
  - Lateral first:
    - Left is legal iff (mask & 0x11111111) == 0 and ((mask >> 1) & settled) == 0.
    - Right is legal iff (mask & 0x88888888) == 0 and ((mask << 1) & settled) == 0.
    - move_left and move_right together: neither applied.
    - An illegal move is dropped silently.
  - Gravity, on the post-lateral mask, when drop_tick = 1:
    - Down is legal iff mask[31:28] == 0 and ((mask << 4) & settled) == 0.
    - Legal: mask <<= 4.
    - Illegal: keep the post-lateral mask and go to LOCK.
- settled never changes during FALL.
- display = settled | mask in FALL/LOCK, settled in IDLE, frozen in GAME_OVER.

## Timing
- Reset: state IDLE; board_out, display, mask, settled = 0; board_valid, busy, game_over = 0.
- load at edge N:
  - FALL and busy = 1 from N+1.
  - display shows spawned board at N+1.
  - With spawn_error: game_over = 1 at N+1 and busy = 0.
- A move or tick sampled at edge N is visible on display after N.
- Blocked drop_tick at edge N:
  - LOCK during N+1 with board_valid = 1 and board_out valid during that cycle.
  - IDLE from N+2; next load accepted at edge N+2.
- board_out holds its value until the next LOCK.
- Reset mid-FALL: piece discarded, all outputs return to reset values next cycle, and no board_valid pulse.

## Configuration
- HARD_DROP_EN defined:
  - Adds the hard_drop input.
  - A hard_drop sampled in FALL enters a DROP state.
  - DROP applies gravity every cycle and ignores lateral requests and drop_tick.
  - When down is illegal, DROP goes to LOCK.
- HARD_DROP_EN undefined: no port, no DROP state; behaviour as above.

## Test plan
- Square fall: load board_in=0x00000066, piece_in=10.
  - display=0x00000066.
  - 6 drop_ticks -> display=0x66000000.
  - 7th tick -> board_valid pulse with board_out=0x66000000, then IDLE.
- Walls, piece 00 (board_in=0x2):
  - move_left -> 0x1; move_left -> 0x1 (blocked).
  - move_right x3 -> 0x2, 0x4, 0x8; 4th move_right -> 0x8.
  - Both move_left and move_right together -> unchanged.
- Stack collision: load board_in=0x00002002, piece 00.
  - Ticks -> display 0x2020, 0x2200.
  - 3rd tick blocked -> board_out=0x00002200.
- Simultaneous: piece 00 at 0x2, move_right + drop_tick in same cycle -> display=0x40.
- Spawn error: load with spawn_error=1 -> game_over=1 next cycle. Later loads and ticks are ignored; reset clears game_over to 0.
- Reset mid-FALL: after 3 ticks, assert reset -> display=0, busy=0, no board_valid; a fresh load is accepted after reset.
